// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register peripheral: register addresses,
// frame geometry and the frame-handling FSM state type.
package spi_reg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Pin synchroniser with edge detection.
// An asynchronous input passes through SYNC_STAGES flops (must be >= 2),
// then one history flop; rise/fall are single-cycle pulses in the clk domain.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset (clears all flops)
//   async_in   : raw pin
//   level      : synchronised level
//   rise, fall : one-cycle pulses on synchronised 0->1 / 1->0 transitions
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   hist_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      hist_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], async_in};
      hist_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = level & ~hist_p;
  assign fall  = ~level & hist_p;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI target giving an off-chip host write access to the five 8-bit PWM
// configuration registers. Frames are 16 bits, MSB first:
//   bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
// A frame commits only if exactly 16 bits arrived, it is a write and the
// address is <= MAX_ADDR.
// Optional build macro: SPI_READBACK_EN -- R/W=0 frames become reads that
// shift the addressed register out on cipo; without it cipo is tied to 0.
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   sclk, copi, ncs   : SPI pins (asynchronous to clk)
//   cipo              : SPI data out
//   en_reg_out_7_0 .. pwm_duty_cycle : registers 0x00..0x04
//   cfg_update        : one-cycle pulse on every committed write
module spi_reg_peripheral
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update
);

  localparam logic [6:0] MAX_ADDR_L = 7'(MAX_ADDR);
  localparam logic [4:0] CNT_FULL   = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT    = 5'(FRAME_BITS + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  state_e      state, state_nxt;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_q;
  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_valid;
  logic        cipo_bit;

  // ---- Stage: pin synchronisers ----
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_in(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_in(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  // ---- Stage: frame FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ncs_fall) state_nxt = SHIFT;
      SHIFT:   if (ncs_rise) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_update = 1'b0;
    cipo       = 1'b0;
    if (state == COMMIT) cfg_update = frame_valid;
    if (state == SHIFT)  cipo       = cipo_bit;
  end

  // ---- Stage: deserialiser ----
  // Counter saturates one past a full frame so over-long frames stay invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state == IDLE && ncs_fall) begin
      bit_cnt <= '0;
    end else if (state == SHIFT && sclk_rise && bit_cnt != CNT_SAT) begin
      bit_cnt <= bit_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && ncs_fall) shift_q <= '0;
    else if (state == SHIFT && sclk_rise) shift_q <= {shift_q[14:0], copi_level};
  end

  assign frame_addr  = shift_q[14:8];
  assign frame_data  = shift_q[7:0];
  assign frame_valid = (bit_cnt == CNT_FULL) && shift_q[FRAME_BITS-1] &&
                       (frame_addr <= MAX_ADDR_L);

  // ---- Stage: register bank ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
      pwm_duty_cycle  <= 8'h00;
    end else if (cfg_update) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
        ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
        default: ;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  // ---- Stage: readback shifter ----
  // Address is complete on the 8th sclk rise (bit_cnt == 7 before it), so the
  // incoming copi bit is the address LSB. Bit 7 sits on cipo through the
  // following fall; shifting starts with the fall after frame bit 7.
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] rd_sr;

  assign rd_addr = {shift_q[5:0], copi_level};

  always_comb begin
    rd_data = 8'h00;
    if (rd_addr <= MAX_ADDR_L) begin
      case (rd_addr)
        ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
        ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
        ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
        ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
        ADDR_DUTY:      rd_data = pwm_duty_cycle;
        default:        rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && ncs_fall) begin
      rd_sr <= 8'h00;
    end else if (state == SHIFT) begin
      if (sclk_rise && bit_cnt == 5'd7 && !shift_q[6]) rd_sr <= rd_data;
      else if (sclk_fall && bit_cnt >= 5'd9)           rd_sr <= {rd_sr[6:0], 1'b0};
    end
  end

  assign cipo_bit = rd_sr[7];

  logic unused_pins;
  assign unused_pins = &{1'b0, sclk_level, copi_rise, copi_fall, ncs_level};
`else
  assign cipo_bit = 1'b0;

  logic unused_pins;
  assign unused_pins = &{1'b0, sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};
`endif

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed testbench for spi_reg_peripheral. A register-level model (array of
// five bytes plus an expected cfg_update flag) is updated from each frame's
// decoded meaning; a compare process checks every DUT output each cycle.
module tb_spi_reg_peripheral;

  localparam int SYNC = 2;
  localparam int H    = 4;   // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic       cipo, cfg_update;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  int checks = 0;
  int errors = 0;
  int cfg_seen = 0;
  bit checking = 1'b0;

  logic [7:0] m_reg [5];
  logic       m_cfg;

  always #5 clk = ~clk;

  spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .cfg_update(cfg_update)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled 1 time unit after posedge.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("en_reg_out_7_0",  en_reg_out_7_0,  m_reg[0]);
      chk("en_reg_out_15_8", en_reg_out_15_8, m_reg[1]);
      chk("en_reg_pwm_7_0",  en_reg_pwm_7_0,  m_reg[2]);
      chk("en_reg_pwm_15_8", en_reg_pwm_15_8, m_reg[3]);
      chk("pwm_duty_cycle",  pwm_duty_cycle,  m_reg[4]);
      chk("cfg_update", {7'b0, cfg_update}, {7'b0, m_cfg});
`ifndef SPI_READBACK_EN
      chk("cipo", {7'b0, cipo}, 8'h00);
`endif
      if (cfg_update === 1'b1) cfg_seen++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_cfg = 1'b0;
  endtask

  // Shift nbits of bits out MSB first; cipo captured at each rise of frame bits 7..0.
  task automatic shift_bits(input logic [31:0] bits, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(H);
      sclk = 1'b1;
      if (i < 8) rd[i] = cipo;
      wait_clk(H);
      sclk = 1'b0;
    end
    wait_clk(H);
  endtask

  task automatic frame(input logic [31:0] bits, input int nbits);
    logic [7:0] rd;
    logic [6:0] addr;
    bit         wr_ok;
    addr  = bits[14:8];
    wr_ok = (nbits == 16) && bits[15] && (addr <= 7'd4);
    ncs = 1'b0;
    wait_clk(H);
    shift_bits(bits, nbits, rd);
    ncs = 1'b1;
    repeat (SYNC + 1) @(posedge clk);
    m_cfg = wr_ok;
    @(posedge clk);
    m_cfg = 1'b0;
    if (wr_ok) m_reg[addr] = bits[7:0];
    wait_clk(H);
`ifdef SPI_READBACK_EN
    if (nbits == 16 && !bits[15])
      chk("readback", rd, (addr <= 7'd4) ? m_reg[addr] : 8'h00);
`endif
  endtask

  initial begin
    logic [7:0] rd;
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    model_reset();
    checking = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(10);

    // Single write to register 0
    frame(32'h80F0, 16);
    chk("lit_out_lo", en_reg_out_7_0, 8'hF0);
    chk("lit_out_hi", en_reg_out_15_8, 8'h00);
    chk_int("cfg_count_1", cfg_seen, 1);

    // Two writes
    frame(32'h8480, 16);
    frame(32'h8280, 16);
    chk("lit_duty", pwm_duty_cycle, 8'h80);
    chk("lit_pwm_lo", en_reg_pwm_7_0, 8'h80);
    chk_int("cfg_count_3", cfg_seen, 3);

    // Frames that must commit nothing
    frame(32'h8555, 16);       // address above MAX_ADDR
    frame(32'h40F8, 15);       // aborted after 15 bits
    frame(32'h181AA, 17);      // 17 bits; last 16 look like a valid write
    frame(32'h00AA, 16);       // R/W = 0
    chk_int("cfg_count_invalid", cfg_seen, 3);
    chk("lit_out_lo_kept", en_reg_out_7_0, 8'hF0);
    chk("lit_out_hi_kept", en_reg_out_15_8, 8'h00);

    // sclk activity with ncs high is ignored
    for (int i = 0; i < 16; i++) begin
      copi = i[0];
      wait_clk(H); sclk = 1'b1;
      wait_clk(H); sclk = 1'b0;
    end
    wait_clk(10);
    chk_int("cfg_count_ncs_high", cfg_seen, 3);

    // Reset mid-frame, then finish the frame: nothing may commit
    ncs = 1'b0;
    wait_clk(H);
    shift_bits(32'h81, 8, rd);
    rst_n = 1'b0;
    model_reset();
    wait_clk(3);
    chk("lit_rst_out_lo", en_reg_out_7_0, 8'h00);
    chk("lit_rst_duty", pwm_duty_cycle, 8'h00);
    chk("lit_rst_pwm_lo", en_reg_pwm_7_0, 8'h00);
    rst_n = 1'b1;
    shift_bits(32'hFF, 8, rd);
    ncs = 1'b1;
    wait_clk(10);
    chk("lit_after_abort_hi", en_reg_out_15_8, 8'h00);

    frame(32'h81FF, 16);
    chk("lit_out_hi_ff", en_reg_out_15_8, 8'hFF);
    chk_int("cfg_count_after_rst", cfg_seen, 4);

    // Rewriting the same value still pulses cfg_update
    frame(32'h81FF, 16);
    chk_int("cfg_count_same_val", cfg_seen, 5);

    frame(32'h835A, 16);
    chk("lit_pwm_hi", en_reg_pwm_15_8, 8'h5A);

`ifdef SPI_READBACK_EN
    ncs = 1'b0; wait_clk(H);
    shift_bits(32'h0300, 16, rd);
    ncs = 1'b1; wait_clk(10);
    chk("lit_read_5a", rd, 8'h5A);
    ncs = 1'b0; wait_clk(H);
    shift_bits(32'h0600, 16, rd);
    ncs = 1'b1; wait_clk(10);
    chk("lit_read_bad_addr", rd, 8'h00);
    frame(32'h0400, 16);
    chk_int("cfg_count_reads", cfg_seen, 6);
    chk("cipo_idle", {7'b0, cipo}, 8'h00);
`endif

    wait_clk(5);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
SPI target that gives the off-chip host write access to the PWM peripheral's five 8-bit configuration registers.
- Host pins come in through ui_in[2:0].
- Pins are synchronised into the clk domain and deserialised into 16-bit frames.
- Valid write frames commit into the register bank, which drives pwm_peripheral directly.
- Sits in the top-level between the dedicated inputs and pwm_peripheral.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each pin synchroniser (must be >= 2)
MAX_ADDR, 4, highest valid register address; frames addressed above it are discarded

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
sclk  input  1  SPI clock pin (ui_in[0]); asynchronous to clk
copi  input  1  SPI data in (ui_in[1]); sampled on sclk rising edge
ncs  input  1  SPI chip select (ui_in[2]); active-low
cipo  output  1  SPI data out; constant 0 unless SPI_READBACK_EN
en_reg_out_7_0  output  8  register 0x00
en_reg_out_15_8  output  8  register 0x01
en_reg_pwm_7_0  output  8  register 0x02
en_reg_pwm_15_8  output  8  register 0x03
pwm_duty_cycle  output  8  register 0x04
cfg_update  output  1  one-cycle pulse when any register is written

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n is low, all five registers are 0x00, cfg_update=0, cipo=0, FSM is in IDLE, the bit counter is 0 and all synchronisers are cleared.
- Synchronisers: sclk, copi and ncs each pass through SYNC_STAGES flops, plus one history flop for edge detection. The host guarantees an SCLK period of at least 8 clk periods.
- Frame format: 16 bits, MSB first.
  - bit15 = R/W (1 = write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- FSM, IDLE: entered from reset and after COMMIT. A detected ncs falling edge clears the shift register and bit counter, then goes to SHIFT.
- FSM, SHIFT: each synced sclk rising edge shifts copi into bit0 and increments a 5-bit counter. The counter saturates at 17. A synced ncs rising edge goes to COMMIT.
- FSM, COMMIT: lasts one cycle. The frame is valid iff all of the following hold:
  - counter == 16
  - bit15 == 1
  - address <= MAX_ADDR
  
  If valid, the addressed register takes data[7:0] on this edge and cfg_update pulses high for exactly this cycle. Then the FSM goes to IDLE.
- Latency: with SYNC_STAGES=2, the register value changes on the 3rd rising clk edge after the ncs rise is first sampled. Generally this is SYNC_STAGES+1 edges.
- Frames that commit nothing: fewer than 16 bits (aborted frame), more than 16 bits, R/W = 0, or address > MAX_ADDR. No register changes and no cfg_update pulse.
- sclk edges while ncs is high are ignored.
- A write that reproduces the current value still pulses cfg_update.
- Reset asserted mid-frame: immediate return to the reset state. The partial frame is lost. The first frame after reset release must begin with a fresh ncs fall.
- Registers hold their value indefinitely between frames.

Optional Feature:
SPI_READBACK_EN
- With the macro: a frame with R/W = 0 is a read.
  - After bit 8 (the last address bit) is shifted in, the addressed register is latched into an 8-bit output shift register.
  - Its MSB drives cipo, advancing on each subsequent synced sclk falling edge.
  - Bits 7..0 are presented during frame bits 7..0.
  - An invalid address returns 0x00.
  - A read never modifies registers and never pulses cfg_update.
  - cipo returns to 0 in IDLE.
- Without the macro: cipo is tied to 0, read frames are discarded, and the output shift register is not built.

Decomposition:
- Shared package spi_reg_pkg holds:
  - address constants: ADDR_EN_OUT_LO = 7'h00, ADDR_EN_OUT_HI = 7'h01, ADDR_EN_PWM_LO = 7'h02, ADDR_EN_PWM_HI = 7'h03, ADDR_DUTY = 7'h04
  - FRAME_BITS = 16
  - FSM state enum: IDLE, SHIFT, COMMIT
- One sub-module, sync_edge_detect: SYNC_STAGES synchroniser plus rise/fall pulse outputs. It is instantiated three times, once each for sclk, copi and ncs.

Test Plan:
- Write frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 three clk edges after ncs rise; one-cycle cfg_update; other registers stay 0x00.
- Write 0x8480 then 0x8280 -> pwm_duty_cycle = 0x80 and en_reg_pwm_7_0 = 0x80; two cfg_update pulses.
- Invalid frames: write to addr 0x05 (0x8555), a 15-bit frame, a 17-bit frame, and R/W = 0 (0x00AA) without the macro -> all registers unchanged, no cfg_update.
- sclk toggled 16 times with ncs high -> no change. rst_n pulsed low after 8 bits of 0x81FF -> all registers 0x00; a subsequent full 0x81FF frame -> en_reg_out_15_8 = 0xFF.
- With SPI_READBACK_EN: after writing 0x835A, read frame 0x0300 -> cipo shifts out 0x5A MSB first during bits 7..0; read of addr 0x06 -> 0x00; registers unchanged.
